// File: rtl/register_op_driver_if.sv
// Command and register-drive bundle for register_op_driver.
// master = command issuer / register side, slave = the driver itself.
interface register_op_driver_if #(
   parameter int NBits = 4,
   parameter int CntW  = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [NBits-1:0] cmd_data;
   logic [CntW-1:0]  cmd_count;
   logic [1:0]       reg_funsel;
   logic             reg_e;
   logic [NBits-1:0] reg_i;
   logic [NBits-1:0] reg_q;
   logic             busy;
   logic             done;
   logic             mismatch;
   logic [NBits-1:0] expected;

   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_count, reg_q,
      input  cmd_ready, reg_funsel, reg_e, reg_i, busy, done, mismatch, expected
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_count, reg_q,
      output cmd_ready, reg_funsel, reg_e, reg_i, busy, done, mismatch, expected
   );
endinterface

// File: rtl/register_op_driver.sv
// Expands clear/load/count commands into funsel/enable drive and checks reg_q (REGDRV_SATURATE_EN: counts stop at the limit).
// Latency: accept edge, N issue cycles, one CHECK cycle; next accept N+2 cycles later.
// Backpressure: cmd_ready only in IDLE; cmd_valid elsewhere is ignored, nothing is queued.
module register_op_driver #(
   parameter int NBits = 4,
   parameter int CntW  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   register_op_driver_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;

   localparam logic [1:0] OP_CLR = 2'b00;
   localparam logic [1:0] OP_LD  = 2'b01;
   localparam logic [1:0] OP_DN  = 2'b10;
   localparam logic [1:0] OP_UP  = 2'b11;

   localparam logic [NBits-1:0] ALL_ONES = '1;

   logic [1:0]       state;
   logic [CntW-1:0]  steps;
   logic [NBits-1:0] expected;
   logic [NBits-1:0] reg_i;
   logic [1:0]       reg_funsel;
   logic             reg_e;
   logic             mismatch;

   logic [CntW-1:0]  start_steps;
   logic [NBits-1:0] start_exp;
   logic [NBits-1:0] exp_step;
   logic             start_blocked;
   logic             sat_hit;
   logic             last_step;

   always_comb begin
      start_steps = bus.cmd_op[1] ? bus.cmd_count : CntW'(1);
      case (bus.cmd_op)
         OP_CLR:  start_exp = '0;
         OP_LD:   start_exp = bus.cmd_data;
         default: start_exp = bus.reg_q;
      endcase
      exp_step = (reg_funsel == OP_UP) ? expected + 1'b1 : expected - 1'b1;
`ifdef REGDRV_SATURATE_EN
      start_blocked = ((bus.cmd_op == OP_UP) && (bus.reg_q == ALL_ONES)) ||
                      ((bus.cmd_op == OP_DN) && (bus.reg_q == '0));
      // The step that lands on the limit is the last one issued.
      sat_hit = ((reg_funsel == OP_UP) && (exp_step == ALL_ONES)) ||
                ((reg_funsel == OP_DN) && (exp_step == '0));
`else
      start_blocked = 1'b0;
      sat_hit       = 1'b0;
`endif
      last_step = (steps == CntW'(1)) || sat_hit;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         steps      <= '0;
         expected   <= '0;
         reg_i      <= '0;
         reg_funsel <= OP_CLR;
         reg_e      <= 1'b0;
         mismatch   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  mismatch   <= 1'b0;
                  reg_funsel <= bus.cmd_op;
                  reg_i      <= (bus.cmd_op == OP_LD) ? bus.cmd_data : '0;
                  expected   <= start_exp;
                  steps      <= start_steps;
                  if ((start_steps == '0) || start_blocked) begin
                     state <= S_CHECK;
                     reg_e <= 1'b0;
                  end else begin
                     state <= S_ISSUE;
                     reg_e <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               steps <= steps - 1'b1;
               if (reg_funsel[1]) expected <= exp_step;
               if (last_step) begin
                  state <= S_CHECK;
                  reg_e <= 1'b0;
               end
            end
            S_CHECK: begin
               if (bus.reg_q != expected) mismatch <= 1'b1;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               reg_e <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cmd_ready  = (state == S_IDLE);
   assign bus.busy       = (state != S_IDLE);
   assign bus.done       = (state == S_CHECK);
   assign bus.reg_funsel = reg_funsel;
   assign bus.reg_e      = reg_e;
   assign bus.reg_i      = reg_i;
   assign bus.mismatch   = mismatch;
   assign bus.expected   = expected;
endmodule

// File: doc/register_op_driver.md
Name: register_op_driver

Overview:
- Initiator for the 2-bit funsel/enable register interface; the counterpart of the NBits register with clear/load/decrement/increment.
- Accepts one command over a valid/ready handshake.
- Expands the command into per-cycle reg_funsel/reg_e/reg_i drive.
- Reads back reg_q and flags any mismatch against an internal model of the register value.
- Sits between the control unit and a bank register; usable by the bench as a register exerciser.

Parameters:
NBits, 4, width of the driven register's data.
CntW, 8, width of the step-count field.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  reset; synchronous, active-low.
cmd_valid  input  1  command offered.
cmd_ready  output  1  driver idle and able to accept.
cmd_op  input  2  00 clear, 01 load, 10 count down, 11 count up.
cmd_data  input  NBits  load value (op 01 only).
cmd_count  input  CntW  number of steps (ops 10/11 only).
reg_funsel  output  2  to register funsel; same encoding as cmd_op.
reg_e  output  1  to register enable.
reg_i  output  NBits  to register data input.
reg_q  input  NBits  register output, read back.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse at command completion.
mismatch  output  1  sticky compare-fail flag.
expected  output  NBits  model value of the register.

Behaviour:
- Register contract: the register samples at the rising edge ending a cycle with reg_e=1.
  - funsel 00 clears, 01 loads reg_i, 10 decrements, 11 increments.
  - Arithmetic is mod 2^NBits.
  - reg_e=0 holds the register.
- All outputs except cmd_ready/busy/done are registered. cmd_ready, busy and done are decoded from state.
- FSM states: IDLE, ISSUE, CHECK.
- IDLE:
  - cmd_ready=1, reg_e=0.
  - On cmd_valid & cmd_ready, capture op/data/count and clear mismatch.
  - Initialise expected: clear -> 0; load -> cmd_data; count -> current reg_q (snapshot).
  - Set steps: clear/load -> 1; count -> cmd_count.
  - If steps=0, go to CHECK; otherwise go to ISSUE.
- ISSUE:
  - reg_e=1, reg_funsel=op; reg_i=data for load, 0 otherwise.
  - Each cycle: steps decrements. For count ops, expected steps ±1 mod 2^NBits.
  - Leave for CHECK when the final step issues.
  - Exactly N consecutive reg_e=1 cycles, no gaps.
- CHECK:
  - reg_e=0, done=1 for this single cycle.
  - If reg_q != expected, set mismatch.
  - Next state is IDLE.
- Latency: accept edge -> N issue cycles -> 1 CHECK cycle. The next command can be accepted N+2 cycles after the previous one.
- cmd_valid outside IDLE is ignored; no queueing.
- mismatch holds until the next accept or reset.
- Wrap-around: up from all-ones -> 0; down from 0 -> all-ones. The model tracks the wrap.
- CntW > NBits is legal; long counts wrap repeatedly.
- Reset (rst_n=0 at an edge), including mid-ISSUE:
  - state=IDLE, reg_e=0, reg_funsel=00, reg_i=0, expected=0, mismatch=0, steps=0.
  - No done pulse for the aborted command.
  - Already-issued steps are not undone; the driven register is not reset by this block.

Optional Feature:
REGDRV_SATURATE_EN
- Defined:
  - Count-up stops issuing once expected reaches all-ones; count-down stops once expected reaches 0.
  - Remaining steps are discarded and the FSM goes to CHECK immediately.
  - A count command starting at the limit issues zero steps.
  - Clear/load are unaffected.
- Undefined: counts wrap as described above.

Test Plan:
1. Reset, then load cmd_data=1010 -> one cycle reg_e=1, funsel=01, reg_i=1010; next cycle done=1, reg_q=1010, mismatch=0; cmd_ready=1 the cycle after.
2. Clear, then count up cmd_count=17 (NBits=4) -> 17 consecutive reg_e=1/funsel=11 cycles; final reg_q=expected=0001, mismatch=0. With REGDRV_SATURATE_EN: 15 cycles, reg_q=1111.
3. Load 0001, then count down cmd_count=3 -> reg_q 0000, 1111, 1110; done with expected=1110, mismatch=0.
4. Count up cmd_count=0 -> no reg_e cycle; done asserts the cycle after accept; expected equals reg_q snapshot.
5. Bench forces reg_q stuck at 0000, then load 0110 -> done with mismatch=1. mismatch stays 1 through idle and clears on the next accept.
6. Count up cmd_count=10, drop rst_n during the 5th issue cycle -> the following cycle has reg_e=0, cmd_ready=1, busy=0, no done. A cmd_valid pulse during ISSUE is ignored (issue count unchanged).
